// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with a valid/ready handshake, burst accumulate mode
// and a 2-entry result FIFO carrying zero/parity flags and a saturating beat count.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNTW-1:0]  out_beats
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] fifo_y_q     [2];
  logic             fifo_zero_q  [2];
  logic             fifo_par_q   [2];
  logic [CNTW-1:0]  fifo_beats_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;

  logic             in_fire, pop, push;
  logic [WIDTH-1:0] push_y, fold;
  logic [CNTW-1:0]  push_beats, cnt_inc;

  assign in_ready  = (count_q < 2'd2);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Unary ops 6/7 ignore the second operand, so the fold becomes NOT acc / PASS acc.
  assign fold    = logic_op(op_q, acc_q, in_a);
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_y     = '0;
    push_beats = '0;
    if (in_fire) begin
      if (state_q == IDLE) begin
        if (!in_acc) begin
          push       = 1'b1;
          push_y     = logic_op(in_op, in_a, in_b);
          push_beats = CNT_ONE;
        end else if (in_last) begin
          push       = 1'b1;
          push_y     = in_a;
          push_beats = CNT_ONE;
        end else begin
          acc_d   = in_a;
          op_d    = in_op;
          cnt_d   = CNT_ONE;
          state_d = ACCUM;
        end
      end else if (in_last) begin
        push       = 1'b1;
        push_y     = fold;
        push_beats = cnt_inc;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = IDLE;
      end else begin
        acc_d = fold;
        cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_y_q[i]     <= '0;
        fifo_zero_q[i]  <= 1'b1;
        fifo_par_q[i]   <= 1'b0;
        fifo_beats_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) begin
        fifo_y_q[wr_ptr_q]     <= push_y;
        fifo_zero_q[wr_ptr_q]  <= (push_y == '0);
        fifo_par_q[wr_ptr_q]   <= ^push_y;
        fifo_beats_q[wr_ptr_q] <= push_beats;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Empty FIFO presents the reset view rather than stale entries.
  assign out_y      = out_valid ? fifo_y_q[rd_ptr_q]     : '0;
  assign out_zero   = out_valid ? fifo_zero_q[rd_ptr_q]  : 1'b1;
  assign out_parity = out_valid ? fifo_par_q[rd_ptr_q]   : 1'b0;
  assign out_beats  = out_valid ? fifo_beats_q[rd_ptr_q] : '0;

endmodule
